// File: rtl/uart_rx_fifo.sv
// Receive buffer between the UART receiver and the read side: stores {error, character}
// pairs, presents the oldest entry first-word-fall-through, and drives RTS with hysteresis.
//
// RTS state | meaning
// ACCEPT    | RTS=1, remote end may keep sending
// HOLD      | RTS=0, occupancy went high; wait for it to drain to RTS_ON_LEVEL
module uart_rx_fifo #(
    parameter int DATA_BITS     = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int RTS_OFF_LEVEL = 6,
    parameter int RTS_ON_LEVEL  = 3
) (
    input  logic                              SysClk,
    input  logic                              Rst,
    input  logic [DATA_BITS-1:0]              Rx_Data,
    input  logic [2:0]                        Rx_Err,
    input  logic                              Data_Rdy,
    input  logic                              Read_Done,
    input  logic                              Overflow_Clr,
    output logic [DATA_BITS-1:0]              Data_Out,
    output logic [2:0]                        Err_Out,
    output logic                              FIFO_Empty,
    output logic                              FIFO_Full,
    output logic                              FIFO_Overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   Count,
    output logic                              RTS
);

    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = DATA_BITS + 3;

    typedef enum logic {
        ACCEPT = 1'b0,
        HOLD   = 1'b1
    } rts_state_t;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, wr_inc, rd_inc;
    logic [CNT_W-1:0]   count_q, count_nxt;
    logic               empty_q, full_q, ovf_q, data_rdy_q;
    logic [ENTRY_W-1:0] head_q, head_nxt, wdata;
    logic               push_req, pop_acc, push_acc, drop;
    rts_state_t         rts_state, rts_state_nxt;

    assign push_req = Data_Rdy & ~data_rdy_q;
    assign pop_acc  = Read_Done & ~empty_q;
    // A full FIFO still accepts a push when a pop frees the head slot on the same edge.
    assign push_acc = push_req & (~full_q | pop_acc);
    assign drop     = push_req & full_q & ~pop_acc;
    assign wdata    = {Rx_Err, Rx_Data};

    assign wr_inc = (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
    assign rd_inc = (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);

    always_comb begin
        count_nxt = count_q;
        if (push_acc && !pop_acc) begin
            count_nxt = count_q + CNT_W'(1);
        end else if (pop_acc && !push_acc) begin
            count_nxt = count_q - CNT_W'(1);
        end
    end

    // Head register: follows the next entry, or keeps the last popped value once empty.
    always_comb begin
        head_nxt = head_q;
        if (pop_acc) begin
            if (count_q == CNT_W'(1)) begin
                if (push_acc) begin
                    head_nxt = wdata;
                end
            end else begin
                head_nxt = mem[rd_inc];
            end
        end else if (empty_q && push_acc) begin
            head_nxt = wdata;
        end
    end

    always_ff @(posedge SysClk) begin
        if (push_acc) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            ovf_q      <= 1'b0;
            data_rdy_q <= 1'b0;
            head_q     <= '0;
        end else begin
            data_rdy_q <= Data_Rdy;
            count_q    <= count_nxt;
            empty_q    <= (count_nxt == '0);
            full_q     <= (count_nxt == CNT_W'(FIFO_DEPTH));
            head_q     <= head_nxt;
            ovf_q      <= drop | (ovf_q & ~Overflow_Clr);
            if (push_acc) begin
                wr_ptr <= wr_inc;
            end
            if (pop_acc) begin
                rd_ptr <= rd_inc;
            end
        end
    end

    always_ff @(posedge SysClk or negedge Rst) begin
        if (!Rst) begin
            rts_state <= ACCEPT;
        end else begin
            rts_state <= rts_state_nxt;
        end
    end

    always_comb begin
        rts_state_nxt = rts_state;
        case (rts_state)
            ACCEPT: if (count_nxt >= CNT_W'(RTS_OFF_LEVEL)) rts_state_nxt = HOLD;
            HOLD:   if (count_nxt <= CNT_W'(RTS_ON_LEVEL))  rts_state_nxt = ACCEPT;
            default: rts_state_nxt = ACCEPT;
        endcase
    end

    assign Data_Out      = head_q[DATA_BITS-1:0];
    assign Err_Out       = head_q[DATA_BITS +: 3];
    assign FIFO_Empty    = empty_q;
    assign FIFO_Full     = full_q;
    assign FIFO_Overflow = ovf_q;
    assign Count         = count_q;
    assign RTS           = (rts_state == ACCEPT);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed and random steps checked every cycle against a
// queue-based model of the receive buffer.
module tb_uart_rx_fifo;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             SysClk = 1'b0;
    logic             Rst;
    logic [7:0]       Rx_Data;
    logic [2:0]       Rx_Err;
    logic             Data_Rdy;
    logic             Read_Done;
    logic             Overflow_Clr;
    logic [7:0]       Data_Out;
    logic [2:0]       Err_Out;
    logic             FIFO_Empty;
    logic             FIFO_Full;
    logic             FIFO_Overflow;
    logic [CNT_W-1:0] Count;
    logic             RTS;

    uart_rx_fifo #(
        .DATA_BITS(8), .FIFO_DEPTH(DEPTH), .RTS_OFF_LEVEL(6), .RTS_ON_LEVEL(3)
    ) dut (
        .SysClk(SysClk), .Rst(Rst), .Rx_Data(Rx_Data), .Rx_Err(Rx_Err),
        .Data_Rdy(Data_Rdy), .Read_Done(Read_Done), .Overflow_Clr(Overflow_Clr),
        .Data_Out(Data_Out), .Err_Out(Err_Out), .FIFO_Empty(FIFO_Empty),
        .FIFO_Full(FIFO_Full), .FIFO_Overflow(FIFO_Overflow), .Count(Count), .RTS(RTS)
    );

    always #5 SysClk = ~SysClk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state: queue of {err, data} entries in arrival order.
    logic [10:0] q[$];
    logic [10:0] m_last;
    logic        m_ovf, m_rts, m_dr_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_last = '0;
        m_ovf  = 1'b0;
        m_rts  = 1'b1;
        m_dr_q = 1'b0;
    endtask

    task automatic check_all();
        logic [10:0] head;
        head = (q.size() > 0) ? q[0] : m_last;
        chk("count",    32'(Count),         32'(q.size()));
        chk("empty",    32'(FIFO_Empty),    32'(q.size() == 0));
        chk("full",     32'(FIFO_Full),     32'(q.size() == DEPTH));
        chk("overflow", 32'(FIFO_Overflow), 32'(m_ovf));
        chk("rts",      32'(RTS),           32'(m_rts));
        chk("data_out", 32'(Data_Out),      32'(head[7:0]));
        chk("err_out",  32'(Err_Out),       32'(head[10:8]));
    endtask

    task automatic step(input logic dr, input logic [7:0] d, input logic [2:0] e,
                        input logic rd, input logic clr);
        logic push, pop, drop;
        Data_Rdy = dr; Rx_Data = d; Rx_Err = e; Read_Done = rd; Overflow_Clr = clr;
        push   = dr & ~m_dr_q;
        m_dr_q = dr;
        pop    = rd && (q.size() > 0);
        if (pop) m_last = q.pop_front();
        drop = push && (q.size() >= DEPTH);
        if (push && !drop) q.push_back({e, d});
        if (clr)  m_ovf = 1'b0;
        if (drop) m_ovf = 1'b1;
        if (m_rts && q.size() >= 6)       m_rts = 1'b0;
        else if (!m_rts && q.size() <= 3) m_rts = 1'b1;
        @(posedge SysClk);
        #1;
        check_all();
    endtask

    task automatic push(input logic [7:0] d, input logic [2:0] e);
        step(1'b1, d, e, 1'b0, 1'b0);
        step(1'b0, d, e, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 8'h00, 3'h0, 1'b1, 1'b0);
    endtask

    initial begin
        Rst = 1'b0; Data_Rdy = 0; Rx_Data = 0; Rx_Err = 0; Read_Done = 0; Overflow_Clr = 0;
        model_reset();
        #12;
        check_all();
        @(negedge SysClk);
        Rst = 1'b1;

        // Three pushes, FWFT head, then pops.
        push(8'h41, 3'd0);
        push(8'h42, 3'd2);
        push(8'h43, 3'd1);
        chk("three_count", 32'(Count), 32'd3);
        chk("three_head",  32'(Data_Out), 32'h41);
        pop();
        chk("pop1_head", 32'(Data_Out), 32'h42);
        chk("pop1_err",  32'(Err_Out),  32'd2);
        pop();
        chk("pop2_head", 32'(Data_Out), 32'h43);
        pop();
        chk("drained_empty", 32'(FIFO_Empty), 32'd1);

        // Held Data_Rdy yields a single push.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h55, 3'd0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        chk("held_rdy_count", 32'(Count), 32'd1);
        pop();

        // Fill, overflow, drain.
        for (int i = 0; i < 8; i++) push(8'(i), 3'(i));
        chk("fill_full", 32'(FIFO_Full), 32'd1);
        chk("fill_rts",  32'(RTS), 32'd0);
        push(8'hFF, 3'd7);
        chk("ovf_set",   32'(FIFO_Overflow), 32'd1);
        chk("ovf_count", 32'(Count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", 32'(Data_Out), 32'(i));
            pop();
        end
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);

        // Full with simultaneous push+pop across pointer wrap.
        for (int i = 0; i < 8; i++) push(8'($urandom), 3'($urandom));
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'($urandom), 3'($urandom), 1'b1, 1'b0);
            step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        end
        chk("pp_full_ovf", 32'(FIFO_Overflow), 32'd0);
        for (int i = 0; i < 8; i++) pop();

        // Pop when empty; overflow set beats clear.
        pop();
        chk("empty_pop_count", 32'(Count), 32'd0);
        for (int i = 0; i < 8; i++) push(8'(8'hA0 + i), 3'd0);
        step(1'b1, 8'hEE, 3'd0, 1'b0, 1'b1);
        chk("set_beats_clr", 32'(FIFO_Overflow), 32'd1);
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        chk("clr_alone", 32'(FIFO_Overflow), 32'd0);
        for (int i = 0; i < 8; i++) pop();

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 8'($urandom), 3'($urandom),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
        step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        while (q.size() > 0) pop();

        // Asynchronous reset with five entries held.
        for (int i = 0; i < 5; i++) push(8'(8'h10 + i), 3'd1);
        Data_Rdy = 0; Read_Done = 0; Overflow_Clr = 0;
        #3;
        Rst = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge SysClk);
        Rst = 1'b1;
        push(8'h99, 3'd0);
        chk("post_reset_data",  32'(Data_Out), 32'h99);
        chk("post_reset_count", 32'(Count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
